// File: rtl/bcd_convert_seq_if.sv
// Start/done handshake bundle between the binary counter and the BCD converter.
// The master side launches conversions; the slave side is the converter itself.
interface bcd_convert_seq_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) ();
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank_mask;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank_mask, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank_mask, overflow
  );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// producing packed BCD digits, a leading-zero blank mask and an overflow flag.
module bcd_convert_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  bcd_convert_seq_if.slave bus
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [31:0] max_val_f(input int d);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < d; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_val_f(DIGITS);

  function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [SW-1:0] saturate(input logic [SW-1:0] s, input logic ovf);
    if (ovf) return {DIGITS{4'd9}};
    return s;
  endfunction

  // Bit i is set when digit i and every digit above it are zero; units never blank.
  function automatic logic [DIGITS-1:0] blank_mask_f(input logic [SW-1:0] s);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (s[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_next_q, ovf_next_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [SW-1:0]     scratch_adj;
  logic [SW-1:0]     scratch_sh;
  logic [SW-1:0]     bcd_sat;

  assign scratch_adj = add3_digits(scratch_q);
  assign scratch_sh  = {scratch_adj[SW-2:0], shift_q[WIDTH-1]};
  assign bcd_sat     = saturate(scratch_sh, ovf_next_q);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_next_d = ({{(32-WIDTH){1'b0}}, bus.bin_in} > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_sh;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = bcd_sat;
          blank_d = blank_mask_f(bcd_sat);
          ovf_d   = ovf_next_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= blank_mask_f('0);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  // Conversion scratch state only matters while in SHIFT, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    scratch_q  <= scratch_d;
    cnt_q      <= cnt_d;
    ovf_next_q <= ovf_next_d;
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = done_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.blank_mask = blank_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: directed handshake cases plus swept and
// randomized values against a decimal-arithmetic reference model.
module tb_bcd_convert_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;

  bcd_convert_seq_if #(.WIDTH(10), .DIGITS(3)) bus_a ();
  bcd_convert_seq_if #(.WIDTH(4),  .DIGITS(1)) bus_b ();

  bcd_convert_seq #(.WIDTH(10), .DIGITS(3)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a.slave));
  bcd_convert_seq #(.WIDTH(4),  .DIGITS(1)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: digits by division, blank when the value is below 10^i.
  function automatic void model(input int unsigned v, input int digits,
                                output logic [31:0] bcd, output logic [31:0] blank,
                                output logic ovf);
    int unsigned lim, p;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    bcd   = '0;
    blank = '0;
    if (v > lim - 1) begin
      ovf = 1'b1;
      for (int i = 0; i < digits; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      ovf = 1'b0;
      p   = 1;
      for (int i = 0; i < digits; i++) begin
        bcd[4*i +: 4] = 4'((v / p) % 10);
        if (i >= 1) blank[i] = (v < p);
        p = p * 10;
      end
    end
  endfunction

  // Launch from a non-edge time with the DUT idle; returns #1 after the done edge.
  task automatic conv_a(input int unsigned v, input string tag);
    logic [31:0] eb, em;
    logic        eo;
    int          k;
    bus_a.start  = 1'b1;
    bus_a.bin_in = 10'(v);
    @(posedge clk); #1;
    bus_a.start  = 1'b0;
    bus_a.bin_in = 10'($urandom);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus_a.done) break;
    end
    model(v, 3, eb, em, eo);
    check({tag, " latency"}, 32'(k), 32'd10);
    check({tag, " bcd"}, 32'(bus_a.bcd_out), eb);
    check({tag, " blank"}, 32'(bus_a.blank_mask), em);
    check({tag, " ovf"}, 32'(bus_a.overflow), 32'(eo));
    check({tag, " busy_at_done"}, 32'(bus_a.busy), 32'd0);
  endtask

  task automatic conv_b(input int unsigned v, input string tag);
    logic [31:0] eb, em;
    logic        eo;
    int          k;
    bus_b.start  = 1'b1;
    bus_b.bin_in = 4'(v);
    @(posedge clk); #1;
    bus_b.start  = 1'b0;
    bus_b.bin_in = 4'($urandom);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus_b.done) break;
    end
    model(v, 1, eb, em, eo);
    check({tag, " latency"}, 32'(k), 32'd4);
    check({tag, " bcd"}, 32'(bus_b.bcd_out), eb);
    check({tag, " blank"}, 32'(bus_b.blank_mask), em);
    check({tag, " ovf"}, 32'(bus_b.overflow), 32'(eo));
  endtask

  initial begin
    int n_done, first_done;

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.start = 1'b0; bus_a.bin_in = '0;
    bus_b.start = 1'b0; bus_b.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  32'(bus_a.busy), 32'd0);
    check("rst done",  32'(bus_a.done), 32'd0);
    check("rst bcd",   32'(bus_a.bcd_out), 32'h000);
    check("rst blank", 32'(bus_a.blank_mask), 32'b110);
    check("rst ovf",   32'(bus_a.overflow), 32'd0);
    check("rst blank_b", 32'(bus_b.blank_mask), 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(posedge clk); #1;

    conv_a(0, "zero");
    conv_a(57, "v57");
    conv_a(999, "v999_b2b");
    conv_a(1023, "v1023");
    conv_a(105, "v105");
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus_a.done), 32'd0);

    // Start while busy is dropped.
    bus_a.start = 1'b1; bus_a.bin_in = 10'd300;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin bus_a.start = 1'b1; bus_a.bin_in = 10'd7; end
      else bus_a.start = 1'b0;
      if (bus_a.done) begin
        n_done++;
        if (n_done == 1) first_done = c;
      end
    end
    check("ignored_start latency", 32'(first_done), 32'd10);
    check("ignored_start dones", 32'(n_done), 32'd1);
    check("ignored_start bcd", 32'(bus_a.bcd_out), 32'h300);

    // Reset mid-conversion aborts without done.
    bus_a.start = 1'b1; bus_a.bin_in = 10'd512;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    check("abort busy",  32'(bus_a.busy), 32'd0);
    check("abort done",  32'(bus_a.done), 32'd0);
    check("abort bcd",   32'(bus_a.bcd_out), 32'h000);
    check("abort blank", 32'(bus_a.blank_mask), 32'b110);
    check("abort ovf",   32'(bus_a.overflow), 32'd0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (bus_a.done) n_done++; end
    check("abort no_done", 32'(n_done), 32'd0);
    conv_a(512, "after_abort");

    // Reset wins over a simultaneous start.
    reset_a = 1'b1; bus_a.start = 1'b1; bus_a.bin_in = 10'd77;
    @(posedge clk); #1;
    reset_a = 1'b0; bus_a.start = 1'b0;
    check("rst_start busy", 32'(bus_a.busy), 32'd0);
    n_done = 0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (bus_a.done) n_done++; end
    check("rst_start no_done", 32'(n_done), 32'd0);

    for (int v = 0; v < 1024; v++) conv_a(v, "sweep");

    for (int r = 0; r < 100; r++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      conv_a($urandom_range(0, 1023), "rand");
    end

    conv_b(9, "d1_v9");
    conv_b(10, "d1_v10");
    for (int v = 0; v < 16; v++) conv_b(v, "d1_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
